// File: rtl/ringosc_freq_meter.sv
// Self-measuring ring oscillator: an odd inverter chain, closed into a gated
// ring or driven open-loop from ext_in, with one tap synchronised into clk and
// its rising edges counted over a programmable gate window.

module ringosc_inv (
  input  logic a,
  output logic y
);
  assign y = ~a;
endmodule

module ringosc_freq_meter #(
  parameter int unsigned CHAIN_LENGTH  = 3889,
  parameter int unsigned NUM_TAPS      = 8,
  parameter int unsigned COUNT_WIDTH   = 16,
  parameter int unsigned GATE_WIDTH    = 16,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        mode_ring,
  input  logic                        ext_in,
  input  logic [$clog2(NUM_TAPS)-1:0] tap_sel,
  input  logic [GATE_WIDTH-1:0]       gate_cycles,
  output logic                        tap_out,
  output logic                        busy,
  output logic                        done,
  output logic [COUNT_WIDTH-1:0]      count,
  output logic                        overflow
);

  localparam int unsigned TAP_W = $clog2(NUM_TAPS);
  localparam int unsigned SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned CNT_W = (GATE_WIDTH > SET_W) ? GATE_WIDTH : SET_W;

  if (CHAIN_LENGTH % 2 == 0) begin : g_len_check
    $error("ringosc_freq_meter: CHAIN_LENGTH must be odd");
  end
  if (SETTLE_CYCLES == 0) begin : g_settle_check
    $error("ringosc_freq_meter: SETTLE_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_MEASURE, S_DONE} state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [TAP_W-1:0]       tap_sel_q, tap_sel_d;
  logic [GATE_WIDTH-1:0]  gate_q, gate_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   overflow_q, overflow_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [2:0]             sync_q, sync_d;

  logic                   ring_run;
  logic                   stage0_in;
  logic [NUM_TAPS-1:0]    taps;
  logic                   rise;

  assign ring_run = busy_q;

  // Each stage lives in its own generate scope so every node is a distinct
  // net; the cells carry keep attributes so synthesis cannot collapse the ring.
  for (genvar i = 0; i < CHAIN_LENGTH; i++) begin : g_stage
    logic a;
    logic y;
    if (i == 0) begin : g_first
      assign a = stage0_in;
    end else begin : g_next
      assign a = g_stage[i-1].y;
    end
    (* keep = "true", dont_touch = "true" *)
    ringosc_inv u_inv (.a(a), .y(y));
  end

  assign stage0_in = mode_ring ? (ring_run & g_stage[CHAIN_LENGTH-1].y) : ext_in;

  for (genvar t = 0; t < NUM_TAPS; t++) begin : g_tap
    localparam int unsigned IDX = ((t + 1) * CHAIN_LENGTH / NUM_TAPS) - 1;
    assign taps[t] = g_stage[IDX].y;
  end

  assign tap_out = taps[tap_sel_q];

  // sync_q[0]/[1] form the synchroniser, sync_q[2] is the edge-detect delay
  assign rise = sync_q[1] & ~sync_q[2];

  // Next-state logic for the measurement sequencer, counter and synchroniser
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tap_sel_d  = tap_sel_q;
    gate_d     = gate_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    sync_d     = {sync_q[1:0], tap_out};
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_SETTLE;
          cnt_d      = '0;
          tap_sel_d  = tap_sel;
          gate_d     = gate_cycles;
          count_d    = '0;
          overflow_d = 1'b0;
        end
      end
      S_SETTLE: begin
        if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = (gate_q == '0) ? S_DONE : S_MEASURE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_MEASURE: begin
        if (rise) begin
          if (count_q == '1) overflow_d = 1'b1;
          else               count_d    = count_q + 1'b1;
        end
        if (cnt_q == CNT_W'(gate_q) - CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d == S_SETTLE) || (state_d == S_MEASURE);
    done_d = (state_d == S_DONE);
  end

  // State register with registered status outputs and synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      tap_sel_q  <= '0;
      gate_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sync_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tap_sel_q  <= tap_sel_d;
      gate_q     <= gate_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      sync_q     <= sync_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_ringosc_freq_meter.sv
// Bench for ringosc_freq_meter: a full-length instance and a short-chain
// 4-bit-counter instance share every input; expected counts come from the
// recorded ext_in history through the tap inversion parity and a 2-cycle
// synchroniser delay.

module tb_ringosc_freq_meter;

  localparam int CL     = 3889;
  localparam int CS     = 15;
  localparam int SETTLE = 4;

  logic        clk = 1'b0;
  logic        rst, start, mode_ring, ext_in;
  logic [2:0]  tap_sel;
  logic [15:0] gate_cycles;

  logic        tap_out_m, busy_m, done_m, ovf_m;
  logic [15:0] count_m;
  logic        tap_out_s, busy_s, done_s, ovf_s;
  logic [3:0]  count_s;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  logic ext_hist[$];

  always #5 clk = ~clk;

  ringosc_freq_meter dut (
    .clk(clk), .rst(rst), .start(start), .mode_ring(mode_ring), .ext_in(ext_in),
    .tap_sel(tap_sel), .gate_cycles(gate_cycles), .tap_out(tap_out_m),
    .busy(busy_m), .done(done_m), .count(count_m), .overflow(ovf_m)
  );

  ringosc_freq_meter #(.CHAIN_LENGTH(CS), .COUNT_WIDTH(4)) dut_s (
    .clk(clk), .rst(rst), .start(start), .mode_ring(mode_ring), .ext_in(ext_in),
    .tap_sel(tap_sel), .gate_cycles(gate_cycles), .tap_out(tap_out_s),
    .busy(busy_s), .done(done_s), .count(count_s), .overflow(ovf_s)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Tap t sits after ((t+1)*L/8) inverters counted from stage0_in
  function automatic logic tap_lvl(input int l, input int t, input logic e);
    int n;
    n = (t + 1) * l / 8;
    return e ^ logic'(n % 2);
  endfunction

  function automatic logic ext_val(input int kind, input int period, input int n);
    if (kind == 0) return logic'((n % period) < (period / 2));
    return logic'($urandom_range(1, 0));
  endfunction

  // Rising edges of the tap, delayed two cycles by the synchroniser,
  // that fall inside the gate window following the settle period.
  function automatic int exp_rises(input int l, input int t, input int s, input int gate);
    int r;
    r = 0;
    for (int m = s + SETTLE + 1; m <= s + SETTLE + gate; m++)
      if (tap_lvl(l, t, ext_hist[m-2]) && !tap_lvl(l, t, ext_hist[m-3])) r++;
    return r;
  endfunction

  task automatic cycle();
    ext_hist.push_back(ext_in);
    @(posedge clk);
    cyc++;
    #1;
  endtask

  // extra: 0 = plain, 1 = second start mid-MEASURE, 2 = start during DONE
  task automatic measure(input string tag, input int tap, input int gate,
                         input int kind, input int period, input int extra);
    int s, k_done, dones, em, es;
    s      = cyc;
    k_done = SETTLE + gate + 1;
    dones  = 0;
    em     = 0;
    es     = 0;
    tap_sel     = 3'(tap);
    gate_cycles = 16'(gate);
    start       = 1'b1;
    ext_in      = ext_val(kind, period, cyc);
    #1;
    cycle();
    for (int k = 1; k <= k_done + 3; k++) begin
      chk({tag, "_done_m"}, int'(done_m), int'(k == k_done));
      chk({tag, "_done_s"}, int'(done_s), int'(k == k_done));
      chk({tag, "_busy_m"}, int'(busy_m), int'(k < k_done));
      if (done_m) dones++;
      if (k == k_done) begin
        em = exp_rises(CL, tap, s, gate);
        es = exp_rises(CS, tap, s, gate);
      end
      if (k >= k_done) begin
        chk({tag, "_count_m"}, int'(count_m), em);
        chk({tag, "_ovf_m"},   int'(ovf_m), 0);
        chk({tag, "_count_s"}, int'(count_s), (es > 15) ? 15 : es);
        chk({tag, "_ovf_s"},   int'(ovf_s), int'(es > 15));
      end
      start = ((extra == 1) && (k == SETTLE + 1 + gate / 2)) ||
              ((extra == 2) && (k == k_done));
      if (start) begin
        tap_sel     = 3'(tap ^ 5);
        gate_cycles = 16'(gate + 9);
      end
      ext_in = ext_val(kind, period, cyc);
      #1;
      chk({tag, "_tap_m"}, int'(tap_out_m), int'(tap_lvl(CL, tap, ext_in)));
      chk({tag, "_tap_s"}, int'(tap_out_s), int'(tap_lvl(CS, tap, ext_in)));
      cycle();
    end
    start = 1'b0;
    chk({tag, "_ndone"}, dones, 1);
  endtask

  initial begin
    int last_tap;
    rst = 1'b1; start = 1'b0; mode_ring = 1'b0; ext_in = 1'b0;
    tap_sel = '0; gate_cycles = '0;
    #1;
    for (int i = 0; i < 3; i++) cycle();
    rst = 1'b0;

    chk("rst_busy",  int'(busy_m), 0);
    chk("rst_done",  int'(done_m), 0);
    chk("rst_count", int'(count_m), 0);
    chk("rst_ovf",   int'(ovf_m), 0);
    ext_in = 1'b1;
    #1;
    chk("rst_tap_m", int'(tap_out_m), int'(tap_lvl(CL, 0, ext_in)));
    chk("rst_tap_s", int'(tap_out_s), int'(tap_lvl(CS, 0, ext_in)));
    for (int i = 0; i < 3; i++) cycle();

    measure("sq8", 7, 80, 0, 8, 0);
    chk("sq8_range", int'(count_m >= 9 && count_m <= 11), 1);

    measure("zero", 3, 0, 1, 0, 0);
    chk("zero_count", int'(count_m), 0);

    measure("sat", 7, 100, 0, 4, 0);
    chk("sat_count_s", int'(count_s), 15);
    chk("sat_ovf_s",   int'(ovf_s), 1);
    chk("sat_count_m", int'(count_m), 25);

    measure("busy2", 5, 60, 1, 0, 1);
    measure("donestart", 0, 30, 0, 6, 2);
    last_tap = 0;

    // Closed ring while idle: ring_run is low, so every tap is a fixed level
    mode_ring = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ext_in = logic'($urandom_range(1, 0));
      #1;
      chk("ring_idle_m", int'(tap_out_m), int'(tap_lvl(CL, last_tap, 1'b0)));
      chk("ring_idle_s", int'(tap_out_s), int'(tap_lvl(CS, last_tap, 1'b0)));
      chk("ring_idle_busy", int'(busy_m), 0);
      cycle();
    end
    mode_ring = 1'b0;

    // Reset in the middle of MEASURE
    tap_sel = 3'd7; gate_cycles = 16'd200; start = 1'b1; ext_in = 1'b0;
    #1;
    cycle();
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      ext_in = ext_val(0, 4, cyc);
      #1;
      cycle();
    end
    chk("pre_rst_busy", int'(busy_m), 1);
    rst = 1'b1;
    ext_in = ext_val(0, 4, cyc);
    #1;
    cycle();
    rst = 1'b0;
    chk("mid_rst_busy",    int'(busy_m), 0);
    chk("mid_rst_done",    int'(done_m), 0);
    chk("mid_rst_count_m", int'(count_m), 0);
    chk("mid_rst_ovf_m",   int'(ovf_m), 0);
    chk("mid_rst_count_s", int'(count_s), 0);
    chk("mid_rst_ovf_s",   int'(ovf_s), 0);
    chk("mid_rst_tap",     int'(tap_out_m), int'(tap_lvl(CL, 0, ext_in)));
    measure("after_rst", 2, 20, 0, 6, 0);

    for (int r = 0; r < 6; r++) begin
      measure("rand", int'($urandom_range(7, 0)), int'($urandom_range(150, 1)),
              int'($urandom_range(1, 0)), int'($urandom_range(12, 2)), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
